// File: rtl/mem_access_unit_pkg.sv
// Shared constants for the memory-access stage.
// Contents:
//   - MMU operation codes.
//   - The stage FSM state type.
//   - A helper that tells whether an op needs a bus access.
package mem_access_unit_pkg;

   localparam logic [1:0] MEM_NOP_OP   = 2'b00;
   localparam logic [1:0] MEM_READ_OP  = 2'b01;
   localparam logic [1:0] MEM_WRITE_OP = 2'b10;

   typedef enum logic [0:0] {
      MEMU_IDLE = 1'b0,
      MEMU_REQ  = 1'b1
   } memu_state_e;

   // 2'b11 is deliberately not a bus op; it behaves like a NOP.
   function automatic logic is_bus_op(input logic [1:0] op);
      return (op == MEM_READ_OP) || (op == MEM_WRITE_OP);
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Bounded-wait counter for bus masters.
// Counts cycles while enabled and flags the last allowed cycle of a wait.
// Ports:
//   clk       - system clock, rising edge
//   rst       - asynchronous active-low reset
//   clr_i     - synchronous clear to zero (wins over en_i)
//   en_i      - increment this cycle
//   expired_o - count has reached LIMIT-1 (registered state only)
module mem_wait_timer #(
   parameter int unsigned LIMIT = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int unsigned CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/mem_access_unit.sv
// Sequential memory-access stage between EXE and MEM/WB.
// NOPs pass straight to the write-back register in one cycle. Reads and writes
// run a req/ack handshake with the MMU. A hung access is aborted after TIMEOUT
// cycles and reported through err_o.
// Ports:
//   clk, rst                        - clock / async active-low reset
//   valid_i, memOp_i, data_i,
//   memAddr_i, regAddr_wb_i, we_i   - instruction from EXE
//   ready_o                         - low stalls EXE (state decode only)
//   memReq_o, memOp_o, ramAddr_o,
//   ramData_o                       - registered request to the MMU
//   memAck_i, data_MMU_i            - MMU completion and read data
//   valid_o, data_wb_o,
//   regAddr_wb_o, we_o              - MEM/WB output register
//   err_o, errAddr_o                - timeout pulse and last timed-out address
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned ADDR_W  = 16,
   parameter int unsigned REG_AW  = 4,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid_i,
   input  logic [1:0]        memOp_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic [ADDR_W-1:0] memAddr_i,
   input  logic [REG_AW-1:0] regAddr_wb_i,
   input  logic              we_i,
   output logic              ready_o,
   output logic              memReq_o,
   output logic [1:0]        memOp_o,
   output logic [ADDR_W-1:0] ramAddr_o,
   output logic [DATA_W-1:0] ramData_o,
   input  logic              memAck_i,
   input  logic [DATA_W-1:0] data_MMU_i,
   output logic              valid_o,
   output logic [DATA_W-1:0] data_wb_o,
   output logic [REG_AW-1:0] regAddr_wb_o,
   output logic              we_o,
   output logic              err_o,
   output logic [ADDR_W-1:0] errAddr_o
);

   memu_state_e       state_q, state_d;
   logic              mem_req_q, mem_req_d;
   logic [1:0]        mem_op_q, mem_op_d;
   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic [DATA_W-1:0] ram_data_q, ram_data_d;
   // Write-back target of the in-flight access, published on completion.
   logic [REG_AW-1:0] pend_reg_q, pend_reg_d;
   logic              pend_we_q, pend_we_d;
   logic              valid_q, valid_d;
   logic [DATA_W-1:0] data_wb_q, data_wb_d;
   logic [REG_AW-1:0] reg_wb_q, reg_wb_d;
   logic              we_q, we_d;
   logic              err_q, err_d;
   logic [ADDR_W-1:0] err_addr_q, err_addr_d;

   logic timer_clr, timer_en, timer_expired;

   mem_wait_timer #(
      .LIMIT(TIMEOUT)
   ) u_wait_timer (
      .clk      (clk),
      .rst      (rst),
      .clr_i    (timer_clr),
      .en_i     (timer_en),
      .expired_o(timer_expired)
   );

   always_comb begin
      state_d    = state_q;
      mem_req_d  = mem_req_q;
      mem_op_d   = mem_op_q;
      ram_addr_d = ram_addr_q;
      ram_data_d = ram_data_q;
      pend_reg_d = pend_reg_q;
      pend_we_d  = pend_we_q;
      valid_d    = 1'b0;
      data_wb_d  = data_wb_q;
      reg_wb_d   = reg_wb_q;
      we_d       = we_q;
      err_d      = 1'b0;
      err_addr_d = err_addr_q;
      timer_clr  = 1'b0;
      timer_en   = 1'b0;

      unique case (state_q)
         MEMU_IDLE: begin
            if (valid_i) begin
               if (is_bus_op(memOp_i)) begin
                  mem_op_d   = memOp_i;
                  ram_addr_d = memAddr_i;
                  ram_data_d = data_i;
                  pend_reg_d = regAddr_wb_i;
                  pend_we_d  = we_i;
                  mem_req_d  = 1'b1;
                  timer_clr  = 1'b1;
                  state_d    = MEMU_REQ;
               end else begin
                  data_wb_d = data_i;
                  reg_wb_d  = regAddr_wb_i;
                  we_d      = we_i;
                  valid_d   = 1'b1;
               end
            end
         end
         MEMU_REQ: begin
            // Ack takes priority over a simultaneous timeout.
            if (memAck_i) begin
               data_wb_d = (mem_op_q == MEM_READ_OP) ? data_MMU_i : ram_data_q;
               reg_wb_d  = pend_reg_q;
               we_d      = pend_we_q;
               valid_d   = 1'b1;
               mem_req_d = 1'b0;
               state_d   = MEMU_IDLE;
            end else if (timer_expired) begin
               // Retire the instruction without writing the register file.
               reg_wb_d   = pend_reg_q;
               we_d       = 1'b0;
               valid_d    = 1'b1;
               err_d      = 1'b1;
               err_addr_d = ram_addr_q;
               mem_req_d  = 1'b0;
               state_d    = MEMU_IDLE;
            end else begin
               timer_en = 1'b1;
            end
         end
         default: state_d = MEMU_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= MEMU_IDLE;
         mem_req_q  <= 1'b0;
         mem_op_q   <= MEM_NOP_OP;
         ram_addr_q <= '0;
         ram_data_q <= '0;
         pend_reg_q <= '0;
         pend_we_q  <= 1'b0;
         valid_q    <= 1'b0;
         data_wb_q  <= '0;
         reg_wb_q   <= '0;
         we_q       <= 1'b0;
         err_q      <= 1'b0;
         err_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         mem_req_q  <= mem_req_d;
         mem_op_q   <= mem_op_d;
         ram_addr_q <= ram_addr_d;
         ram_data_q <= ram_data_d;
         pend_reg_q <= pend_reg_d;
         pend_we_q  <= pend_we_d;
         valid_q    <= valid_d;
         data_wb_q  <= data_wb_d;
         reg_wb_q   <= reg_wb_d;
         we_q       <= we_d;
         err_q      <= err_d;
         err_addr_q <= err_addr_d;
      end
   end

   assign ready_o      = (state_q == MEMU_IDLE);
   assign memReq_o     = mem_req_q;
   assign memOp_o      = mem_op_q;
   assign ramAddr_o    = ram_addr_q;
   assign ramData_o    = ram_data_q;
   assign valid_o      = valid_q;
   assign data_wb_o    = data_wb_q;
   assign regAddr_wb_o = reg_wb_q;
   assign we_o         = we_q;
   assign err_o        = err_q;
   assign errAddr_o    = err_addr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit with TIMEOUT=8.
// Expected write-back results are queued when an op's outcome is decided and
// popped whenever the DUT pulses valid_o or err_o.
module tb_mem_access_unit;

   localparam int unsigned DATA_W  = 16;
   localparam int unsigned ADDR_W  = 16;
   localparam int unsigned REG_AW  = 4;
   localparam int unsigned TIMEOUT = 8;

   localparam logic [1:0] OP_NOP   = 2'b00;
   localparam logic [1:0] OP_READ  = 2'b01;
   localparam logic [1:0] OP_WRITE = 2'b10;

   logic              clk = 1'b0;
   logic              rst;
   logic              valid_i;
   logic [1:0]        memOp_i;
   logic [DATA_W-1:0] data_i;
   logic [ADDR_W-1:0] memAddr_i;
   logic [REG_AW-1:0] regAddr_wb_i;
   logic              we_i;
   logic              ready_o;
   logic              memReq_o;
   logic [1:0]        memOp_o;
   logic [ADDR_W-1:0] ramAddr_o;
   logic [DATA_W-1:0] ramData_o;
   logic              memAck_i;
   logic [DATA_W-1:0] data_MMU_i;
   logic              valid_o;
   logic [DATA_W-1:0] data_wb_o;
   logic [REG_AW-1:0] regAddr_wb_o;
   logic              we_o;
   logic              err_o;
   logic [ADDR_W-1:0] errAddr_o;

   mem_access_unit #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .REG_AW (REG_AW),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .valid_i     (valid_i),
      .memOp_i     (memOp_i),
      .data_i      (data_i),
      .memAddr_i   (memAddr_i),
      .regAddr_wb_i(regAddr_wb_i),
      .we_i        (we_i),
      .ready_o     (ready_o),
      .memReq_o    (memReq_o),
      .memOp_o     (memOp_o),
      .ramAddr_o   (ramAddr_o),
      .ramData_o   (ramData_o),
      .memAck_i    (memAck_i),
      .data_MMU_i  (data_MMU_i),
      .valid_o     (valid_o),
      .data_wb_o   (data_wb_o),
      .regAddr_wb_o(regAddr_wb_o),
      .we_o        (we_o),
      .err_o       (err_o),
      .errAddr_o   (errAddr_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DATA_W-1:0] data;
      logic              chk_data;
      logic [REG_AW-1:0] rd;
      logic              we;
      logic              err;
      logic [ADDR_W-1:0] err_addr;
   } wb_exp_t;

   wb_exp_t           exp_q[$];
   logic [ADDR_W-1:0] last_err_addr = '0;
   int                n_checks = 0;
   int                n_fail   = 0;
   int                n_pulses = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [DATA_W-1:0] d, input logic cd, input logic [REG_AW-1:0] rd,
                       input logic we, input logic err, input logic [ADDR_W-1:0] ea);
      wb_exp_t e;
      e.data = d; e.chk_data = cd; e.rd = rd; e.we = we; e.err = err;
      if (err) last_err_addr = ea;
      e.err_addr = last_err_addr;
      exp_q.push_back(e);
   endtask

   // Scoreboard: every valid_o/err_o pulse must match the oldest expectation.
   always @(negedge clk) begin
      if (rst && (valid_o || err_o)) begin
         n_pulses++;
         if (exp_q.size() == 0) begin
            check("unexpected_pulse", {30'b0, err_o, valid_o}, 32'd0);
         end else begin
            wb_exp_t e;
            e = exp_q.pop_front();
            check("wb_valid", valid_o, 1);
            if (e.chk_data) check("wb_data", data_wb_o, e.data);
            check("wb_reg", regAddr_wb_o, e.rd);
            check("wb_we", we_o, e.we);
            check("wb_err", err_o, e.err);
            check("wb_err_addr", errAddr_o, e.err_addr);
         end
      end
   end

   task automatic do_nop(input logic [1:0] op, input logic [DATA_W-1:0] d,
                         input logic [REG_AW-1:0] rd, input logic we);
      check("nop_ready", ready_o, 1);
      valid_i = 1'b1; memOp_i = op; data_i = d; regAddr_wb_i = rd; we_i = we;
      push(d, 1'b1, rd, we, 1'b0, '0);
      tick();
      valid_i = 1'b0;
   endtask

   // ack_after = 0 means the MMU never answers and the access must time out.
   task automatic do_mem(input logic [1:0] op, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] d, input logic [REG_AW-1:0] rd,
                         input logic we, input int ack_after, input logic [DATA_W-1:0] rdata);
      check("mem_ready_before", ready_o, 1);
      valid_i = 1'b1; memOp_i = op; data_i = d; memAddr_i = addr; regAddr_wb_i = rd; we_i = we;
      tick();
      valid_i = 1'b0; memAddr_i = '0; data_i = '0;
      for (int i = 1; i <= int'(TIMEOUT); i++) begin
         check("req_high", memReq_o, 1);
         check("req_ready_low", ready_o, 0);
         check("req_addr", ramAddr_o, addr);
         check("req_op", memOp_o, op);
         if (op == OP_WRITE) check("req_wdata", ramData_o, d);
         if (i == ack_after) begin
            memAck_i = 1'b1;
            data_MMU_i = rdata;
            push((op == OP_READ) ? rdata : d, 1'b1, rd, we, 1'b0, '0);
         end else if (ack_after == 0 && i == int'(TIMEOUT)) begin
            push('0, 1'b0, rd, 1'b0, 1'b1, addr);
         end
         tick();
         memAck_i = 1'b0;
         data_MMU_i = '0;
         if (i == ack_after) break;
      end
      check("req_low_after", memReq_o, 0);
   endtask

   initial begin
      rst = 1'b0; valid_i = 1'b0; memOp_i = '0; data_i = '0; memAddr_i = '0;
      regAddr_wb_i = '0; we_i = 1'b0; memAck_i = 1'b0; data_MMU_i = '0;
      repeat (2) @(posedge clk);
      #2;
      check("rst_ready", ready_o, 1);
      check("rst_req", memReq_o, 0);
      check("rst_valid", valid_o, 0);
      check("rst_err", err_o, 0);
      check("rst_data_wb", data_wb_o, 0);
      check("rst_err_addr", errAddr_o, 0);
      check("rst_ram_addr", ramAddr_o, 0);
      rst = 1'b1;
      tick();

      do_nop(OP_NOP, 16'h1234, 4'h3, 1'b1);
      tick();
      do_mem(OP_READ, 16'h0040, 16'h0000, 4'h5, 1'b1, 3, 16'hBEEF);
      tick();
      do_mem(OP_WRITE, 16'h8000, 16'h00FF, 4'h0, 1'b0, 1, 16'hDEAD);
      tick();
      do_mem(OP_READ, 16'h0123, 16'h0000, 4'h7, 1'b1, 0, 16'h0000);
      check("to_err_now", err_o, 1);
      tick();
      check("err_one_cycle", err_o, 0);
      do_mem(OP_READ, 16'h0200, 16'h0000, 4'h2, 1'b1, int'(TIMEOUT), 16'hCAFE);
      check("late_ack_no_err", err_o, 0);

      // Back-to-back: NOP presented in the read's valid_o cycle.
      tick();
      do_mem(OP_READ, 16'h0300, 16'h0000, 4'h8, 1'b1, 2, 16'h1111);
      check("b2b_valid_cycle", valid_o, 1);
      do_nop(OP_NOP, 16'h5555, 4'h9, 1'b1);
      check("b2b_nop_valid", valid_o, 1);
      do_nop(2'b11, 16'hA5A5, 4'hA, 1'b0);

      // Idle cycle with a stray ack: no pulse.
      memAck_i = 1'b1;
      tick();
      memAck_i = 1'b0;
      check("idle_ack_ignored", valid_o, 0);
      check("idle_ack_ready", ready_o, 1);

      // Reset in the second REQ cycle drops the request asynchronously.
      valid_i = 1'b1; memOp_i = OP_READ; memAddr_i = 16'h0777; regAddr_wb_i = 4'h4; we_i = 1'b1;
      tick();
      valid_i = 1'b0;
      tick();
      check("pre_rst_req", memReq_o, 1);
      #2 rst = 1'b0;
      #1;
      check("rst_async_req", memReq_o, 0);
      check("rst_async_ready", ready_o, 1);
      tick();
      #2 rst = 1'b1;
      tick();
      memAck_i = 1'b1; data_MMU_i = 16'h7777;
      tick();
      memAck_i = 1'b0;
      check("post_rst_no_valid", valid_o, 0);
      tick();
      check("post_rst_no_valid2", valid_o, 0);
      check("post_rst_err_addr", errAddr_o, 0);

      check("pulse_count", n_pulses, 8);
      check("queue_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
